fir_coeff_ctrl: RTL and testbench
=================================

Name: fir_coeff_ctrl

Overview:
- AXI4-Lite write slave that receives 3x3 kernel coefficients, normalisation shift and bypass control from the MicroBlaze.
- Writes land in a shadow bank; the bank is committed to the active outputs only at a frame boundary (rising edge of vs_i), so the filter never changes kernel mid-frame.
- Sits between the MicroBlaze peripheral port (M03 AXI) and fir_filter, in the pixel clock domain. The interconnect clock converter handles the CDC.

Parameters:
- NUM_COEFF, 9, number of kernel taps (row-major, tap 4 = centre).
- COEFF_W, 16, signed coefficient width.
- SHIFT_W, 4, width of the right-shift normalisation field.
- ADDR_W, 32, AXI address width; only addr[6:2] decoded.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_awaddr  in  ADDR_W  write address.
- s_awvalid  in  1  address valid.
- s_awready  out  1  address ready.
- s_wdata  in  32  write data.
- s_wstrb  in  4  byte enables.
- s_wvalid  in  1  data valid.
- s_wready  out  1  data ready.
- s_bresp  out  2  write response: OKAY=2'b00, SLVERR=2'b10.
- s_bvalid  out  1  response valid.
- s_bready  in  1  response ready.
- vs_i  in  1  vertical sync from the video path, active high.
- coeff_o  out  NUM_COEFF*COEFF_W  active kernel; tap k at bits [k*COEFF_W +: COEFF_W].
- shift_o  out  SHIFT_W  active normalisation shift.
- bypass_o  out  1  active bypass; filter passes y through unfiltered.
- commit_pending_o  out  1  a commit is armed and waiting for vs_i.
- coeff_update_o  out  1  one-cycle pulse when the active bank is loaded.

Behaviour:
- Address map (byte offsets):
  - 0x00 + 4k: coefficient k, k = 0..NUM_COEFF-1, stored from wdata[COEFF_W-1:0].
  - 0x40: CTRL. bit0 = COMMIT (write-1 self-clearing), bit1 = BYPASS (shadow).
  - 0x44: SHIFT, from wdata[SHIFT_W-1:0].
  - Any other offset: SLVERR, no state change.
- Byte strobes: each written byte updates only where its wstrb bit is 1. COMMIT acts only if wstrb[0]=1 and wdata[0]=1.
- Reset values:
  - Shadow and active coefficients: all 0 except tap 4 = 1 (identity kernel). SHIFT=0, BYPASS=0.
  - s_awready=1, s_wready=1, s_bvalid=0, s_bresp=0.
  - commit_pending_o=0, coeff_update_o=0. Internal vs_q=0.
- Write FSM, states IDLE, WAIT_W, WAIT_AW, RESP:
  - IDLE: awready=wready=1.
    - Both valid in the same cycle: accept both, go to RESP.
    - Only AW valid: latch address, go to WAIT_W.
    - Only W valid: latch data and strobes, go to WAIT_AW.
  - WAIT_W: awready=0, wready=1. On wvalid go to RESP.
  - WAIT_AW: awready=1, wready=0. On awvalid go to RESP.
  - The register write happens on the edge that completes the pair.
  - RESP: bvalid=1, bresp set per decode, awready=wready=0. On bready return to IDLE.
  - Latency: AW+W accepted in cycle N gives the shadow update and bvalid=1 at the edge ending N (visible in N+1). bvalid holds until bready.
- Commit FSM, states IDLE and ARMED:
  - A COMMIT write moves the FSM to ARMED and sets commit_pending_o=1.
  - A COMMIT while ARMED is a no-op (stays ARMED).
  - In ARMED, when vs_i=1 and vs_q=0 (rising edge seen in cycle M):
    - At the edge ending M, active bank <= shadow bank.
    - coeff_update_o=1 for exactly cycle M+1; commit_pending_o=0; return to IDLE.
  - vs_q <= vs_i every cycle.
- Simultaneous events:
  - A shadow write completing in the same cycle as the commit edge is NOT included. The active bank takes the pre-write shadow, and the new value waits for the next commit.
  - A COMMIT write completing in the same cycle as a vs_i rising edge only arms; it commits at the following frame.
- Shadow writes while ARMED are allowed; the latest values at the commit edge are taken.
- No commit edge occurs while vs_i is held high; a commit needs a fresh rising edge.
- Reset asserted mid-transaction or mid-ARMED returns everything to reset values immediately. An outstanding AXI transaction is dropped.

Optional Feature:
- Macro: FIR_COEFF_READBACK_EN.
- Defined: adds AR/R ports (s_araddr, s_arvalid, s_arready, s_rdata[31:0], s_rresp, s_rvalid, s_rready).
  - Reads return the shadow registers, zero-extended.
  - CTRL read returns bit1=BYPASS, bit2=commit_pending; bit0 always reads 0.
  - Read latency is 1 cycle after the AR handshake; rvalid holds until rready.
  - Unmapped address returns SLVERR with rdata=0.
  - Reads are independent of the write FSM.
- Undefined: no read ports exist; the block is write-only.

Decomposition:
- Package fir_pkg holds:
  - NUM_COEFF, COEFF_W, SHIFT_W.
  - Register offsets (COEFF_BASE=0x00, CTRL_OFS=0x40, SHIFT_OFS=0x44).
  - RESP_OKAY / RESP_SLVERR.
  - Reset kernel constant.
- One sub-module: fir_axil_wr_if, containing the AW/W/B FSM. It outputs a single-cycle wr_en, wr_addr, wr_data and wr_strb, and takes the decode error flag back for bresp.

Test Plan:
- Reset: release rst_n, then coeff_o has only tap 4=1, shift_o=0, bypass_o=0 and all AXI readies are high.
- Write 0x0000FFFF to 0x08 (strb 4'hF), AW and W in the same cycle: bvalid in the next cycle with bresp=0. coeff_o unchanged until COMMIT plus a vs_i rising edge, then tap 2=0xFFFF and coeff_update_o pulses for 1 cycle.
- Ordering and back-pressure: W presented 3 cycles before AW, bready held low 5 cycles. bvalid stays high and no second transaction is accepted until bready.
- Write 0x1 to 0x40, then hold vs_i high across the arming: no commit. Lower then raise vs_i: commit happens and commit_pending_o falls in the same cycle coeff_update_o rises.
- Write to 0x30 (unmapped): bresp=2'b10 and no register changes. Write 0x44 with wstrb=4'h0: bresp=OKAY and SHIFT unchanged.
- Assert rst_n low while ARMED with a pending AW: outputs return to reset values within the same cycle, and the next vs_i edge causes no update.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants, register map and state types for the FIR coefficient controller.
// Optional AXI read-back of the shadow bank is built when FIR_COEFF_READBACK_EN is defined.
package fir_pkg;
  localparam int NUM_COEFF  = 9;
  localparam int COEFF_W    = 16;
  localparam int SHIFT_W    = 4;
  localparam int CENTRE_TAP = 4;
  localparam int KERNEL_W   = NUM_COEFF * COEFF_W;

  localparam logic [7:0] COEFF_BASE = 8'h00;
  localparam logic [7:0] CTRL_OFS   = 8'h40;
  localparam logic [7:0] SHIFT_OFS  = 8'h44;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Identity kernel: centre tap = 1, all others 0.
  localparam logic [KERNEL_W-1:0] RESET_KERNEL = KERNEL_W'(1) << (CENTRE_TAP * COEFF_W);

  typedef enum logic [1:0] {WR_IDLE, WR_WAIT_W, WR_WAIT_AW, WR_RESP} wr_state_e;
  typedef enum logic {CM_IDLE, CM_ARMED} cm_state_e;

  function automatic logic [4:0] reg_idx(input logic [7:0] ofs);
    return ofs[6:2];
  endfunction
endpackage

// File: rtl/fir_axil_wr_if.sv
// AXI4-Lite write channel FSM: pairs AW and W in any order, emits a one-cycle
// register write strobe and returns OKAY/SLVERR on B from the decoder's error flag.
module fir_axil_wr_if
  import fir_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] awaddr_i,
  input  logic          awvalid_i,
  output logic          awready_o,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    wstrb_i,
  input  logic          wvalid_i,
  output logic          wready_o,
  output logic [1:0]    bresp_o,
  output logic          bvalid_o,
  input  logic          bready_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [31:0]   wr_data_o,
  output logic [3:0]    wr_strb_o,
  input  logic          wr_err_i,
  output wr_state_e     state_o
);
  // A channel transfers on a clock edge where valid and ready are both high;
  // valid never waits on ready, and payload is captured only on that edge.
  wr_state_e      state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [31:0]    data_q, data_d;
  logic [3:0]     strb_q, strb_d;
  logic [1:0]     bresp_q, bresp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WR_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      bresp_q <= bresp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    awready_o = 1'b0;
    wready_o  = 1'b0;
    wr_en_o   = 1'b0;
    wr_addr_o = addr_q;
    wr_data_o = data_q;
    wr_strb_o = strb_q;
    case (state_q)
      WR_IDLE: begin
        awready_o = 1'b1;
        wready_o  = 1'b1;
        if (awvalid_i && wvalid_i) begin
          wr_en_o   = 1'b1;
          wr_addr_o = awaddr_i;
          wr_data_o = wdata_i;
          wr_strb_o = wstrb_i;
          state_d   = WR_RESP;
        end else if (awvalid_i) begin
          addr_d  = awaddr_i;
          state_d = WR_WAIT_W;
        end else if (wvalid_i) begin
          data_d  = wdata_i;
          strb_d  = wstrb_i;
          state_d = WR_WAIT_AW;
        end
      end
      WR_WAIT_W: begin
        wready_o = 1'b1;
        if (wvalid_i) begin
          wr_en_o   = 1'b1;
          wr_data_o = wdata_i;
          wr_strb_o = wstrb_i;
          state_d   = WR_RESP;
        end
      end
      WR_WAIT_AW: begin
        awready_o = 1'b1;
        if (awvalid_i) begin
          wr_en_o   = 1'b1;
          wr_addr_o = awaddr_i;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bready_i) state_d = WR_IDLE;
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // Kept apart from the main block so the decoder's error path does not loop back into it.
  always_comb begin
    bresp_d = bresp_q;
    if (wr_en_o) bresp_d = wr_err_i ? RESP_SLVERR : RESP_OKAY;
  end

  assign bvalid_o = (state_q == WR_RESP);
  assign bresp_o  = bresp_q;
  assign state_o  = state_q;
endmodule

// File: rtl/fir_coeff_ctrl.sv
// Shadow/active coefficient register bank for fir_filter; shadow commits on vs_i rising edge.
// Define FIR_COEFF_READBACK_EN to add an AXI4-Lite read port returning the shadow registers.
module fir_coeff_ctrl
  import fir_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [31:0]         s_wdata,
  input  logic [3:0]          s_wstrb,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic                vs_i,
`ifdef FIR_COEFF_READBACK_EN
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [31:0]         s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rvalid,
  input  logic                s_rready,
`endif
  output logic [KERNEL_W-1:0] coeff_o,
  output logic [SHIFT_W-1:0]  shift_o,
  output logic                bypass_o,
  output logic                commit_pending_o,
  output logic                coeff_update_o
);
  logic              wr_en, dec_err, commit_wr, vs_rise;
  logic [4:0]        wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  wr_state_e         wr_state;

  cm_state_e            cm_state_q, cm_state_d;
  logic                 vs_q, update_q, update_d;
  logic [KERNEL_W-1:0]  sh_coeff_q, sh_coeff_d, act_coeff_q, act_coeff_d;
  logic [SHIFT_W-1:0]   sh_shift_q, sh_shift_d, act_shift_q, act_shift_d;
  logic                 sh_bypass_q, sh_bypass_d, act_bypass_q, act_bypass_d;

  fir_axil_wr_if #(.AW(5)) u_wr_if (
    .clk       (clk),
    .rst_n     (rst_n),
    .awaddr_i  (s_awaddr[6:2]),
    .awvalid_i (s_awvalid),
    .awready_o (s_awready),
    .wdata_i   (s_wdata),
    .wstrb_i   (s_wstrb),
    .wvalid_i  (s_wvalid),
    .wready_o  (s_wready),
    .bresp_o   (s_bresp),
    .bvalid_o  (s_bvalid),
    .bready_i  (s_bready),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .wr_strb_o (wr_strb),
    .wr_err_i  (dec_err),
    .state_o   (wr_state)
  );

  always_comb begin
    sh_coeff_d   = sh_coeff_q;
    sh_shift_d   = sh_shift_q;
    sh_bypass_d  = sh_bypass_q;
    act_coeff_d  = act_coeff_q;
    act_shift_d  = act_shift_q;
    act_bypass_d = act_bypass_q;
    cm_state_d   = cm_state_q;
    update_d     = 1'b0;
    dec_err      = 1'b1;
    commit_wr    = 1'b0;
    vs_rise      = vs_i && !vs_q;

    for (int k = 0; k < NUM_COEFF; k++) begin
      if (wr_addr == reg_idx(COEFF_BASE) + 5'(k)) begin
        dec_err = 1'b0;
        for (int b = 0; b < COEFF_W / 8; b++)
          if (wr_en && wr_strb[b]) sh_coeff_d[k*COEFF_W + b*8 +: 8] = wr_data[b*8 +: 8];
      end
    end
    if (wr_addr == reg_idx(CTRL_OFS)) begin
      dec_err = 1'b0;
      if (wr_en && wr_strb[0]) begin
        sh_bypass_d = wr_data[1];
        commit_wr   = wr_data[0];
      end
    end
    if (wr_addr == reg_idx(SHIFT_OFS)) begin
      dec_err = 1'b0;
      if (wr_en && wr_strb[0]) sh_shift_d = wr_data[SHIFT_W-1:0];
    end

    // Active bank copies the pre-write shadow; a write landing on this edge waits for the next commit.
    if (cm_state_q == CM_ARMED && vs_rise) begin
      act_coeff_d  = sh_coeff_q;
      act_shift_d  = sh_shift_q;
      act_bypass_d = sh_bypass_q;
      update_d     = 1'b1;
      cm_state_d   = CM_IDLE;
    end
    if (commit_wr) cm_state_d = CM_ARMED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_state_q   <= CM_IDLE;
      vs_q         <= 1'b0;
      update_q     <= 1'b0;
      sh_coeff_q   <= RESET_KERNEL;
      sh_shift_q   <= '0;
      sh_bypass_q  <= 1'b0;
      act_coeff_q  <= RESET_KERNEL;
      act_shift_q  <= '0;
      act_bypass_q <= 1'b0;
    end else begin
      cm_state_q   <= cm_state_d;
      vs_q         <= vs_i;
      update_q     <= update_d;
      sh_coeff_q   <= sh_coeff_d;
      sh_shift_q   <= sh_shift_d;
      sh_bypass_q  <= sh_bypass_d;
      act_coeff_q  <= act_coeff_d;
      act_shift_q  <= act_shift_d;
      act_bypass_q <= act_bypass_d;
    end
  end

  assign coeff_o          = act_coeff_q;
  assign shift_o          = act_shift_q;
  assign bypass_o         = act_bypass_q;
  assign commit_pending_o = (cm_state_q == CM_ARMED);
  assign coeff_update_o   = update_q;

  logic unused_bits;
  assign unused_bits = ^{s_awaddr[ADDR_W-1:7], s_awaddr[1:0], wr_data[31:COEFF_W],
                         wr_strb[3:COEFF_W/8], wr_state};

`ifdef FIR_COEFF_READBACK_EN
  logic        rvalid_q, rvalid_d, rd_err;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d, rd_val;
  logic [4:0]  rd_idx;

  always_comb begin
    rd_idx = s_araddr[6:2];
    rd_err = 1'b1;
    rd_val = '0;
    for (int k = 0; k < NUM_COEFF; k++) begin
      if (rd_idx == reg_idx(COEFF_BASE) + 5'(k)) begin
        rd_err = 1'b0;
        rd_val = 32'(sh_coeff_q[k*COEFF_W +: COEFF_W]);
      end
    end
    if (rd_idx == reg_idx(CTRL_OFS)) begin
      rd_err = 1'b0;
      rd_val = {29'd0, cm_state_q == CM_ARMED, sh_bypass_q, 1'b0};
    end
    if (rd_idx == reg_idx(SHIFT_OFS)) begin
      rd_err = 1'b0;
      rd_val = 32'(sh_shift_q);
    end
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (s_arvalid && !rvalid_q) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
      rdata_d  = rd_val;
    end else if (rvalid_q && s_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  assign s_arready = !rvalid_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;

  logic unused_rd;
  assign unused_rd = ^{s_araddr[ADDR_W-1:7], s_araddr[1:0]};
`endif
endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl: AXI write ordering, byte strobes, decode errors,
// frame-boundary commit timing, and asynchronous reset while armed.
module tb_fir_coeff_ctrl;
  localparam logic [143:0] K    = 144'h1 << 64;
  localparam logic [1:0]   OKAY = 2'b00;
  localparam logic [1:0]   SERR = 2'b10;

  logic         clk, rst_n;
  logic [31:0]  s_awaddr, s_wdata;
  logic [3:0]   s_wstrb;
  logic         s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready, vs_i;
  logic [1:0]   s_bresp;
  logic [143:0] coeff_o;
  logic [3:0]   shift_o;
  logic         bypass_o, commit_pending_o, coeff_update_o;
  logic [148:0] st;

  int tests_run = 0;
  int tests_failed = 0;
  logic [1:0] exp_q[$];
  logic [143:0] a1, a2, a3;

  assign st = {coeff_o, shift_o, bypass_o};

  fir_coeff_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_awaddr         (s_awaddr),
    .s_awvalid        (s_awvalid),
    .s_awready        (s_awready),
    .s_wdata          (s_wdata),
    .s_wstrb          (s_wstrb),
    .s_wvalid         (s_wvalid),
    .s_wready         (s_wready),
    .s_bresp          (s_bresp),
    .s_bvalid         (s_bvalid),
    .s_bready         (s_bready),
    .vs_i             (vs_i),
    .coeff_o          (coeff_o),
    .shift_o          (shift_o),
    .bypass_o         (bypass_o),
    .commit_pending_o (commit_pending_o),
    .coeff_update_o   (coeff_update_o)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [143:0] tap(input int k, input logic [15:0] v);
    return 144'(v) << (k * 16);
  endfunction

  // B phase after a completed AW/W pair; starts and ends just after a rising edge.
  task automatic b_phase(input int bdelay);
    logic [1:0] e;
    @(negedge clk);
    check("bvalid_latency", s_bvalid, 1'b1);
    for (int i = 0; i < bdelay; i++) begin
      @(negedge clk);
      check("bvalid_hold", s_bvalid, 1'b1);
      check("no_accept_in_resp", {s_awready, s_wready}, 2'b00);
    end
    s_bready = 1'b1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
    check("bresp", s_bresp, e);
    @(posedge clk); #1;
    s_bready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp, input int bdelay);
    int n;
    exp_q.push_back(resp);
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(s_awready && s_wready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("aw_w_accept", {s_awready, s_wready}, 2'b11);
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    b_phase(bdelay);
  endtask

  task automatic commit_edge(input logic [148:0] prev, input logic [148:0] nxt);
    vs_i = 1'b1;
    @(negedge clk);
    check("pre_commit_state", st, prev);
    check("pre_commit_flags", {commit_pending_o, coeff_update_o}, 2'b10);
    @(negedge clk);
    check("post_commit_state", st, nxt);
    check("post_commit_flags", {commit_pending_o, coeff_update_o}, 2'b01);
    @(negedge clk);
    check("update_one_cycle", coeff_update_o, 1'b0);
    @(posedge clk); #1;
    vs_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; vs_i = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_held_state", st, {K, 4'd0, 1'b0});
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_state", st, {K, 4'd0, 1'b0});
    check("rst_axi", {s_awready, s_wready, s_bvalid, s_bresp}, 5'b11000);
    check("rst_flags", {commit_pending_o, coeff_update_o}, 2'b00);
    @(posedge clk); #1;

    // Coefficient write lands in shadow only; commit exposes it.
    axi_write(32'h08, 32'h0000FFFF, 4'hF, OKAY, 0);
    @(negedge clk);
    check("shadow_not_active", st, {K, 4'd0, 1'b0});
    check("not_armed", commit_pending_o, 1'b0);
    @(posedge clk); #1;
    axi_write(32'h40, 32'h1, 4'hF, OKAY, 0);
    @(negedge clk);
    check("armed_flags", {commit_pending_o, coeff_update_o}, 2'b10);
    check("armed_no_change", st, {K, 4'd0, 1'b0});
    @(posedge clk); #1;
    a1 = K | tap(2, 16'hFFFF);
    commit_edge({K, 4'd0, 1'b0}, {a1, 4'd0, 1'b0});

    // W three cycles ahead of AW, then bready held low five cycles.
    exp_q.push_back(OKAY);
    s_wdata = 32'h5; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(negedge clk);
    check("w_first_ready", s_wready, 1'b1);
    @(posedge clk); #1;
    s_wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("wait_aw_ready", {s_awready, s_wready, s_bvalid}, 3'b100);
      @(posedge clk); #1;
    end
    s_awaddr = 32'h44; s_awvalid = 1'b1;
    @(negedge clk);
    check("aw_late_ready", s_awready, 1'b1);
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    b_phase(5);
    @(negedge clk);
    check("shift_shadow_only", shift_o, 4'd0);
    @(posedge clk); #1;

    // Arm while vs_i is held high: no commit until a fresh rising edge.
    vs_i = 1'b1;
    @(posedge clk); #1;
    axi_write(32'h00, 32'h0000ABCD, 4'b0010, OKAY, 0);
    axi_write(32'h40, 32'h3, 4'hF, OKAY, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("vs_high_no_commit", {commit_pending_o, coeff_update_o}, 2'b10);
      check("vs_high_state", st, {a1, 4'd0, 1'b0});
      @(posedge clk); #1;
    end
    vs_i = 1'b0;
    @(posedge clk); #1;
    a2 = a1 | tap(0, 16'hAB00);
    commit_edge({a1, 4'd0, 1'b0}, {a2, 4'd5, 1'b1});

    // Unmapped offset and all-zero strobes change nothing.
    axi_write(32'h30, 32'hFFFFFFFF, 4'hF, SERR, 0);
    axi_write(32'h44, 32'hF, 4'h0, OKAY, 0);
    axi_write(32'h40, 32'h3, 4'hF, OKAY, 0);
    @(posedge clk); #1;
    commit_edge({a2, 4'd5, 1'b1}, {a2, 4'd5, 1'b1});

    // Shadow write completing on the commit edge is excluded from that commit.
    axi_write(32'h40, 32'h3, 4'hF, OKAY, 0);
    exp_q.push_back(OKAY);
    vs_i = 1'b1;
    s_awaddr = 32'h20; s_wdata = 32'h7; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge clk);
    check("coincide_accept", {s_awready, s_wready, commit_pending_o}, 3'b111);
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk);
    check("coincide_state", st, {a2, 4'd5, 1'b1});
    check("coincide_flags", {commit_pending_o, coeff_update_o, s_bvalid}, 3'b011);
    s_bready = 1'b1;
    check("coincide_bresp", s_bresp, exp_q.pop_front());
    @(posedge clk); #1;
    s_bready = 1'b0; vs_i = 1'b0;
    axi_write(32'h40, 32'h3, 4'hF, OKAY, 0);
    a3 = a2 | tap(8, 16'h0007);
    commit_edge({a2, 4'd5, 1'b1}, {a3, 4'd5, 1'b1});

    // Reset while armed with an AW outstanding.
    axi_write(32'h40, 32'h1, 4'hF, OKAY, 0);
    s_awaddr = 32'h00; s_awvalid = 1'b1;
    @(negedge clk);
    check("aw_only_ready", s_awready, 1'b1);
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    @(negedge clk);
    check("wait_w_ready", {s_awready, s_wready, commit_pending_o}, 3'b011);
    rst_n = 1'b0;
    #1;
    check("async_rst_state", st, {K, 4'd0, 1'b0});
    check("async_rst_axi", {s_awready, s_wready, s_bvalid, s_bresp}, 5'b11000);
    check("async_rst_flags", {commit_pending_o, coeff_update_o}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vs_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_update", {commit_pending_o, coeff_update_o}, 2'b00);
      check("post_rst_state", st, {K, 4'd0, 1'b0});
    end
    @(posedge clk); #1;
    vs_i = 1'b0;
    axi_write(32'h40, 32'h1, 4'hF, OKAY, 0);
    @(posedge clk); #1;
    commit_edge({K, 4'd0, 1'b0}, {K, 4'd0, 1'b0});

    check("resp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
